// File: rtl/vga_timing_pkg.sv
// Shared VGA timing types and default 640x480@60 porch/sync values.
// Renderers import coord_t from here so they agree on coordinate width.
package vga_timing_pkg;

  localparam int unsigned COORD_W     = 10;
  localparam int unsigned FRAME_CNT_W = 8;

  typedef logic [COORD_W-1:0] coord_t;

  localparam int unsigned H_VISIBLE_DEF = 640;
  localparam int unsigned H_FP_DEF      = 16;
  localparam int unsigned H_SYNC_DEF    = 96;
  localparam int unsigned H_BP_DEF      = 48;
  localparam int unsigned V_VISIBLE_DEF = 480;
  localparam int unsigned V_FP_DEF      = 10;
  localparam int unsigned V_SYNC_DEF    = 2;
  localparam int unsigned V_BP_DEF      = 33;

  localparam int unsigned H_TOTAL_DEF = H_VISIBLE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
  localparam int unsigned V_TOTAL_DEF = V_VISIBLE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

  // Inclusive range test on 10-bit coordinates.
  function automatic logic in_range(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from vga_timing_gen to the renderers.
// frame_cnt exists only when VGA_FRAME_CNT_EN is defined.
interface vga_timing_gen_if;
  import vga_timing_pkg::*;

  coord_t DrawX;
  coord_t DrawY;
  logic   hs;
  logic   vs;
  logic   blank;
  logic   frame_end;
`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt;

  modport master (output DrawX, DrawY, hs, vs, blank, frame_end, frame_cnt);
  modport slave  (input  DrawX, DrawY, hs, vs, blank, frame_end, frame_cnt);
`else
  modport master (output DrawX, DrawY, hs, vs, blank, frame_end);
  modport slave  (input  DrawX, DrawY, hs, vs, blank, frame_end);
`endif

endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter advanced by tick; exposes its next value so
// the parent can register outputs aligned with the counter itself.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned TOTAL = H_TOTAL_DEF
) (
  input  logic   clk,
  input  logic   reset,
  input  logic   tick,
  output coord_t count,
  output coord_t count_nxt_c,
  output logic   wrap
);

  coord_t count_q;
  coord_t count_d;

  always_comb begin
    wrap    = tick && (count_q == COORD_W'(TOTAL - 1));
    count_d = count_q;
    if (reset) begin
      count_d = '0;
    end else if (wrap) begin
      count_d = '0;
    end else if (tick) begin
      count_d = count_q + COORD_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    count_q <= count_d;
  end

  assign count       = count_q;
  assign count_nxt_c = count_d;

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 raster timing: coordinates, syncs, blank and end-of-frame strobe.
// Define VGA_FRAME_CNT_EN to add the 8-bit wrapping frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_VISIBLE = H_VISIBLE_DEF,
  parameter int unsigned H_FP      = H_FP_DEF,
  parameter int unsigned H_SYNC    = H_SYNC_DEF,
  parameter int unsigned H_BP      = H_BP_DEF,
  parameter int unsigned V_VISIBLE = V_VISIBLE_DEF,
  parameter int unsigned V_FP      = V_FP_DEF,
  parameter int unsigned V_SYNC    = V_SYNC_DEF,
  parameter int unsigned V_BP      = V_BP_DEF
) (
  input  logic              vga_clk,
  input  logic              reset,
  vga_timing_gen_if.master  vid
);

  localparam int unsigned H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam coord_t HS_START = COORD_W'(H_VISIBLE + H_FP);
  localparam coord_t HS_END   = COORD_W'(H_VISIBLE + H_FP + H_SYNC - 1);
  localparam coord_t VS_START = COORD_W'(V_VISIBLE + V_FP);
  localparam coord_t VS_END   = COORD_W'(V_VISIBLE + V_FP + V_SYNC - 1);
  localparam coord_t H_VIS_C  = COORD_W'(H_VISIBLE);
  localparam coord_t V_VIS_C  = COORD_W'(V_VISIBLE);

  coord_t x_cnt;
  coord_t y_cnt;
  coord_t x_nxt_c;
  coord_t y_nxt_c;
  logic   h_wrap;
  logic   v_wrap_unused;

  vga_axis_counter #(.TOTAL(H_TOTAL)) u_h_cnt (
    .clk         (vga_clk),
    .reset       (reset),
    .tick        (1'b1),
    .count       (x_cnt),
    .count_nxt_c (x_nxt_c),
    .wrap        (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) u_v_cnt (
    .clk         (vga_clk),
    .reset       (reset),
    .tick        (h_wrap),
    .count       (y_cnt),
    .count_nxt_c (y_nxt_c),
    .wrap        (v_wrap_unused)
  );

  logic hs_q, hs_d;
  logic vs_q, vs_d;
  logic blank_q, blank_d;
  logic frame_end_q, frame_end_d;

  // Decode from the next counter values so the registered flags line up with DrawX/DrawY.
  always_comb begin
    hs_d        = 1'b1;
    vs_d        = 1'b1;
    blank_d     = 1'b1;
    frame_end_d = 1'b0;
    if (!reset) begin
      hs_d        = !in_range(x_nxt_c, HS_START, HS_END);
      vs_d        = !in_range(y_nxt_c, VS_START, VS_END);
      blank_d     = (x_nxt_c < H_VIS_C) && (y_nxt_c < V_VIS_C);
      frame_end_d = (x_nxt_c == '0) && (y_nxt_c == V_VIS_C);
    end
  end

  always_ff @(posedge vga_clk) begin
    hs_q        <= hs_d;
    vs_q        <= vs_d;
    blank_q     <= blank_d;
    frame_end_q <= frame_end_d;
  end

  assign vid.DrawX     = x_cnt;
  assign vid.DrawY     = y_cnt;
  assign vid.hs        = hs_q;
  assign vid.vs        = vs_q;
  assign vid.blank     = blank_q;
  assign vid.frame_end = frame_end_q;

`ifdef VGA_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_cnt_q;
  logic [FRAME_CNT_W-1:0] frame_cnt_d;

  // Advances on the edge that ends the frame_end cycle.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (reset) begin
      frame_cnt_d = '0;
    end else if (frame_end_q) begin
      frame_cnt_d = frame_cnt_q + FRAME_CNT_W'(1);
    end
  end

  always_ff @(posedge vga_clk) begin
    frame_cnt_q <= frame_cnt_d;
  end

  assign vid.frame_cnt = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: default-timing instance plus a shrunken-timing
// instance for whole-frame behaviour; frame_cnt checks under VGA_FRAME_CNT_EN.
module tb_vga_timing_gen;

  localparam int A_HV = 640, A_HF = 16, A_HS = 96, A_HB = 48;
  localparam int A_VV = 480, A_VF = 10, A_VS = 2,  A_VB = 33;
  localparam int A_FT = (A_HV + A_HF + A_HS + A_HB) * (A_VV + A_VF + A_VS + A_VB);

  localparam int B_HV = 8, B_HF = 2, B_HS = 3, B_HB = 3;
  localparam int B_VV = 6, B_VF = 1, B_VS = 2, B_VB = 2;
  localparam int B_HT = B_HV + B_HF + B_HS + B_HB;
  localparam int B_FT = B_HT * (B_VV + B_VF + B_VS + B_VB);

  typedef struct {
    int x;
    int y;
    bit hs;
    bit vs;
    bit blank;
    bit fe;
  } exp_t;

  logic clk = 1'b0;
  logic reset_a = 1'b1;
  logic reset_b = 1'b1;

  int tests = 0;
  int fails = 0;

  vga_timing_gen_if vif_a ();
  vga_timing_gen_if vif_b ();

  vga_timing_gen dut_a (
    .vga_clk (clk),
    .reset   (reset_a),
    .vid     (vif_a)
  );

  vga_timing_gen #(
    .H_VISIBLE(B_HV), .H_FP(B_HF), .H_SYNC(B_HS), .H_BP(B_HB),
    .V_VISIBLE(B_VV), .V_FP(B_VF), .V_SYNC(B_VS), .V_BP(B_VB)
  ) dut_b (
    .vga_clk (clk),
    .reset   (reset_b),
    .vid     (vif_b)
  );

  always #20 clk = ~clk;

  // Raster position from the pixel index within a frame.
  function automatic exp_t model(int idx, int hv, int hf, int hsw, int hb,
                                 int vv, int vf, int vsw);
    exp_t e;
    int   ht;
    ht      = hv + hf + hsw + hb;
    e.x     = idx % ht;
    e.y     = idx / ht;
    e.hs    = !(e.x >= hv + hf && e.x < hv + hf + hsw);
    e.vs    = !(e.y >= vv + vf && e.y < vv + vf + vsw);
    e.blank = (e.x < hv) && (e.y < vv);
    e.fe    = (e.x == 0) && (e.y == vv);
    return e;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cmp(string name, int idx, exp_t e, int x, int y,
                     bit hs, bit vs, bit bl, bit fe);
    tests++;
    if (x != e.x || y != e.y || hs != e.hs || vs != e.vs || bl != e.blank || fe != e.fe) begin
      fails++;
      $display("FAIL model_%s idx=%0d got x=%0d y=%0d hs=%0b vs=%0b blank=%0b fe=%0b expected x=%0d y=%0d hs=%0b vs=%0b blank=%0b fe=%0b",
               name, idx, x, y, hs, vs, bl, fe, e.x, e.y, e.hs, e.vs, e.blank, e.fe);
    end
  endtask

  // Reference positions: index into the frame, cleared by reset.
  int   idx_a = 0, idx_b = 0;
  bit   valid_a = 1'b0, valid_b = 1'b0;
  logic [7:0] fcnt_b = 8'd0;

  always @(posedge clk) begin
    valid_a <= valid_a | reset_a;
    valid_b <= valid_b | reset_b;
    idx_a   <= reset_a ? 0 : (idx_a + 1) % A_FT;
    idx_b   <= reset_b ? 0 : (idx_b + 1) % B_FT;
    if (reset_b)
      fcnt_b <= 8'd0;
    else if (model(idx_b, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS).fe)
      fcnt_b <= fcnt_b + 8'd1;
  end

  bit fcnt_done = 1'b0;
`ifdef VGA_FRAME_CNT_EN
  int pulses_b = 0;
  bit pend_b = 1'b0;
`endif

  always @(negedge clk) begin
    if (valid_a)
      cmp("a", idx_a, model(idx_a, A_HV, A_HF, A_HS, A_HB, A_VV, A_VF, A_VS),
          int'(vif_a.DrawX), int'(vif_a.DrawY), vif_a.hs, vif_a.vs, vif_a.blank, vif_a.frame_end);
    if (valid_b) begin
      cmp("b", idx_b, model(idx_b, B_HV, B_HF, B_HS, B_HB, B_VV, B_VF, B_VS),
          int'(vif_b.DrawX), int'(vif_b.DrawY), vif_b.hs, vif_b.vs, vif_b.blank, vif_b.frame_end);
`ifdef VGA_FRAME_CNT_EN
      chk("frame_cnt_model", int'(vif_b.frame_cnt), int'(fcnt_b));
      if (pend_b) begin
        chk("frame_cnt_after_256", int'(vif_b.frame_cnt), 0);
        pend_b    = 1'b0;
        fcnt_done = 1'b1;
      end
      if (vif_b.frame_end && !fcnt_done) begin
        pulses_b++;
        if (pulses_b == 1) chk("frame_cnt_before_first_inc", int'(vif_b.frame_cnt), 0);
        if (pulses_b == 256) pend_b = 1'b1;
      end
`endif
    end
  end

  initial begin
    int n, hs_low, hs_first, hs_last, blank_fall, hs_752, len;
    int vs_low, fe_cnt, fe_idx, vs_fall, y_last;

    reset_a = 1'b1;
    reset_b = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("rst_x", int'(vif_a.DrawX), 0);
      chk("rst_hs_vs_blank_fe", {vif_a.hs, vif_a.vs, vif_a.blank, vif_a.frame_end}, 4'b1110);
    end
    reset_a = 1'b0;
    reset_b = 1'b0;
    @(negedge clk);
    chk("first_x", int'(vif_a.DrawX), 1);
    chk("first_y", int'(vif_a.DrawY), 0);

    n = 0;
    while (vif_a.DrawX != 10'd799 && n < 2000) begin @(negedge clk); n++; end
    chk("reach_799", int'(vif_a.DrawX), 799);
    @(negedge clk);
    chk("wrap_x", int'(vif_a.DrawX), 0);
    chk("wrap_y", int'(vif_a.DrawY), 1);

    hs_low = 0; hs_first = -1; hs_last = -1; blank_fall = -1; hs_752 = -1;
    for (int i = 0; i < 800; i++) begin
      if (!vif_a.hs) begin
        hs_low++;
        if (hs_first < 0) hs_first = int'(vif_a.DrawX);
        hs_last = int'(vif_a.DrawX);
      end
      if (!vif_a.blank && blank_fall < 0) blank_fall = int'(vif_a.DrawX);
      if (vif_a.DrawX == 10'd752) hs_752 = int'(vif_a.hs);
      @(negedge clk);
    end
    chk("hs_low_len", hs_low, 96);
    chk("hs_first", hs_first, 656);
    chk("hs_last", hs_last, 751);
    chk("hs_at_752", hs_752, 1);
    chk("blank_fall_x", blank_fall, 640);
    chk("line2_y", int'(vif_a.DrawY), 2);

    // Mid-frame reset at (300,20).
    n = 0;
    while (!(vif_a.DrawX == 10'd300 && vif_a.DrawY == 10'd20) && n < 20000) begin
      @(negedge clk); n++;
    end
    chk("reach_300_20", int'(vif_a.DrawX) * 1000 + int'(vif_a.DrawY), 300020);
    reset_a = 1'b1;
    @(negedge clk);
    chk("midrst_xy", int'(vif_a.DrawX) * 1000 + int'(vif_a.DrawY), 0);
    chk("midrst_flags", {vif_a.hs, vif_a.vs, vif_a.blank, vif_a.frame_end}, 4'b1110);
    reset_a = 1'b0;
    @(negedge clk);
    chk("midrst_resume_x", int'(vif_a.DrawX), 1);
    len = 0;
    do begin @(negedge clk); len++; end while (vif_a.DrawX != 10'd0 && len < 2000);
    chk("midrst_line_len", len + 1, 800);
    chk("midrst_line_y", int'(vif_a.DrawY), 1);

    // Whole frame on the shrunken instance.
    n = 0;
    while (!(vif_b.DrawX == 10'd0 && vif_b.DrawY == 10'd0) && n < 2 * B_FT) begin
      @(negedge clk); n++;
    end
    chk("b_frame_start", int'(vif_b.DrawX) + int'(vif_b.DrawY), 0);
    vs_low = 0; fe_cnt = 0; fe_idx = -1; vs_fall = -1; y_last = -1;
    for (int i = 0; i < B_FT; i++) begin
      if (!vif_b.vs) begin
        vs_low++;
        if (vs_fall < 0) vs_fall = i;
      end
      if (vif_b.frame_end) begin fe_cnt++; fe_idx = i; end
      if (i == B_FT - 1) y_last = int'(vif_b.DrawY);
      @(negedge clk);
    end
    chk("b_vs_low", vs_low, 32);
    chk("b_fe_count", fe_cnt, 1);
    chk("b_fe_idx", fe_idx, 96);
    chk("b_vs_fall_idx", vs_fall, 112);
    chk("b_y_before_wrap", y_last, 10);
    chk("b_wrap_xy", int'(vif_b.DrawX) + int'(vif_b.DrawY), 0);

`ifdef VGA_FRAME_CNT_EN
    n = 0;
    while (!fcnt_done && n < 60000) begin @(negedge clk); n++; end
    chk("frame_cnt_256_reached", int'(fcnt_done), 1);
`endif
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
